// File: rtl/cp_pkg.sv
// Shared types and constants for the clock-port strobe qualifier.
package cp_pkg;

  typedef enum logic [2:0] {IDLE, QUAL, ISSUE, HOLD, RECOVER} state_e;
  typedef enum logic [1:0] {K_NONE, K_RD, K_WR, K_ILL} kind_e;

  localparam logic [1:0] REG_DATA = 2'd0;
  localparam logic [1:0] REG_IRQ  = 2'd1;
  localparam logic [1:0] REG_A_LO = 2'd2;
  localparam logic [1:0] REG_A_HI = 2'd3;

  // Classify one synchronised sample of the active-low strobes.
  function automatic kind_e decode_kind(input logic cs_n, input logic rd_n, input logic wr_n);
    kind_e k;
    k = K_NONE;
    if (!cs_n) begin
      unique case ({rd_n, wr_n})
        2'b01:   k = K_RD;
        2'b10:   k = K_WR;
        2'b00:   k = K_ILL;
        default: k = K_NONE;
      endcase
    end
    return k;
  endfunction

endpackage

// File: rtl/cp_sync.sv
// Multi-flop synchroniser with a per-bit reset value.
module cp_sync #(
  parameter int unsigned    WIDTH   = 1,
  parameter int unsigned    DEPTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sync_q [DEPTH];
  logic [WIDTH-1:0] sync_d [DEPTH];

  always_comb begin
    sync_d[0] = d;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        sync_q[i] <= RST_VAL;
      end
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        sync_q[i] <= sync_d[i];
      end
    end
  end

  assign q = sync_q[DEPTH-1];

endmodule

// File: rtl/cp_strobe_qual.sv
// Clock-port front end: synchronise, glitch-filter and turn each bus access
// into exactly one valid/ready command, flagging illegal and late cycles.
module cp_strobe_qual
  import cp_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_CYCLES = 3
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       CS_n,
  input  logic       IORD_n,
  input  logic       IOWR_n,
  input  logic [1:0] A,
  input  logic [7:0] CP_D,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic       cmd_wr,
  output logic [1:0] cmd_a,
  output logic [7:0] cmd_d,
  output logic       busy,
  output logic       err_late,
  output logic       err_illegal,
  input  logic       err_clr,
  output logic [7:0] glitch_cnt
);

  localparam int unsigned CNT_W = (FILT_CYCLES < 2) ? 1 : $clog2(FILT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILT_CYCLES);

  logic [2:0] strb_s;
  logic [9:0] ad_s;

  cp_sync #(.WIDTH(3), .DEPTH(SYNC_STAGES), .RST_VAL(3'b111)) u_sync_strb (
    .clk (CLK),
    .rst (RST),
    .d   ({CS_n, IORD_n, IOWR_n}),
    .q   (strb_s)
  );

  cp_sync #(.WIDTH(10), .DEPTH(SYNC_STAGES), .RST_VAL(10'h000)) u_sync_ad (
    .clk (CLK),
    .rst (RST),
    .d   ({A, CP_D}),
    .q   (ad_s)
  );

  kind_e kind_c;
  kind_e kind_eff_c;

  // Illegal cycles only raise a flag; the sequencer sees them as idle bus.
  always_comb begin
    kind_c     = decode_kind(strb_s[2], strb_s[1], strb_s[0]);
    kind_eff_c = (kind_c == K_ILL) ? K_NONE : kind_c;
  end

  state_e           state_q, state_d;
  kind_e            kind_q, kind_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cmd_valid_q, cmd_valid_d;
  logic             cmd_wr_q, cmd_wr_d;
  logic [1:0]       cmd_a_q, cmd_a_d;
  logic [7:0]       cmd_d_q, cmd_d_d;
  logic             err_late_q, err_late_d;
  logic             err_ill_q, err_ill_d;
  logic [7:0]       glitch_q, glitch_d;
  logic             busy_q, busy_d;

  logic [CNT_W-1:0] cnt_inc;
  logic             capture;
  logic             late_set;
  logic             glitch_inc;

  always_comb begin
    state_d     = state_q;
    kind_d      = kind_q;
    cnt_d       = cnt_q;
    cmd_valid_d = cmd_valid_q;
    cmd_wr_d    = cmd_wr_q;
    cmd_a_d     = cmd_a_q;
    cmd_d_d     = cmd_d_q;
    cnt_inc     = cnt_q + CNT_W'(1);
    capture     = 1'b0;
    late_set    = 1'b0;
    glitch_inc  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (kind_eff_c != K_NONE) begin
          kind_d = kind_eff_c;
          cnt_d  = CNT_W'(1);
          if (FILT_CYCLES == 1) capture = 1'b1;
          else                  state_d = QUAL;
        end
      end
      QUAL: begin
        if (kind_eff_c == kind_q) begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_MAX) capture = 1'b1;
        end else begin
          state_d    = IDLE;
          glitch_inc = 1'b1;
        end
      end
      ISSUE: begin
        if (cmd_ready) begin
          cmd_valid_d = 1'b0;
          cnt_d       = '0;
          state_d     = (kind_eff_c == kind_q) ? HOLD : RECOVER;
        end else if (kind_eff_c == K_NONE) begin
          late_set = 1'b1;
        end
      end
      HOLD: begin
        if (kind_eff_c != kind_q) begin
          state_d = RECOVER;
          cnt_d   = '0;
        end
      end
      RECOVER: begin
        if (kind_eff_c == K_NONE) begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_MAX) state_d = IDLE;
        end else begin
          cnt_d = '0;
        end
      end
      default: begin
        state_d = RECOVER;
        cnt_d   = '0;
      end
    endcase

    if (capture) begin
      state_d     = ISSUE;
      cmd_valid_d = 1'b1;
      cmd_wr_d    = (kind_d == K_WR);
      cmd_a_d     = ad_s[9:8];
      cmd_d_d     = (kind_d == K_WR) ? ad_s[7:0] : 8'h00;
    end

    // Set takes priority over a same-cycle clear.
    err_late_d = late_set | (err_late_q & ~err_clr);
    err_ill_d  = (kind_c == K_ILL) | (err_ill_q & ~err_clr);
    glitch_d   = (glitch_inc && glitch_q != 8'hFF) ? glitch_q + 8'd1 : glitch_q;
    busy_d     = (state_d != IDLE);
  end

  // Reset into RECOVER so a cycle already on the bus is never issued.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= RECOVER;
      kind_q      <= K_NONE;
      cnt_q       <= '0;
      cmd_valid_q <= 1'b0;
      cmd_wr_q    <= 1'b0;
      cmd_a_q     <= 2'd0;
      cmd_d_q     <= 8'h00;
      err_late_q  <= 1'b0;
      err_ill_q   <= 1'b0;
      glitch_q    <= 8'h00;
      busy_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      kind_q      <= kind_d;
      cnt_q       <= cnt_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_wr_q    <= cmd_wr_d;
      cmd_a_q     <= cmd_a_d;
      cmd_d_q     <= cmd_d_d;
      err_late_q  <= err_late_d;
      err_ill_q   <= err_ill_d;
      glitch_q    <= glitch_d;
      busy_q      <= busy_d;
    end
  end

  assign cmd_valid   = cmd_valid_q;
  assign cmd_wr      = cmd_wr_q;
  assign cmd_a       = cmd_a_q;
  assign cmd_d       = cmd_d_q;
  assign err_late    = err_late_q;
  assign err_illegal = err_ill_q;
  assign glitch_cnt  = glitch_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_cp_strobe_qual.sv
// Directed bench for cp_strobe_qual at default parameters.
module tb_cp_strobe_qual;
  import cp_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cs_n = 1'b1, iord_n = 1'b1, iowr_n = 1'b1;
  logic [1:0] a = 2'd0;
  logic [7:0] d = 8'h00;
  logic       cmd_ready = 1'b0;
  logic       err_clr = 1'b0;

  logic       cmd_valid, cmd_wr, busy, err_late, err_illegal;
  logic [1:0] cmd_a;
  logic [7:0] cmd_d, glitch_cnt;

  int vectors = 0;
  int miscompares = 0;
  int hs_cnt = 0;
  int hs_base;
  int n;
  logic        stable;
  logic [10:0] snap;
  logic [10:0] hs_q[$];
  logic [7:0]  wvals [4];

  cp_strobe_qual dut (
    .CLK         (clk),
    .RST         (rst),
    .CS_n        (cs_n),
    .IORD_n      (iord_n),
    .IOWR_n      (iowr_n),
    .A           (a),
    .CP_D        (d),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_wr      (cmd_wr),
    .cmd_a       (cmd_a),
    .cmd_d       (cmd_d),
    .busy        (busy),
    .err_late    (err_late),
    .err_illegal (err_illegal),
    .err_clr     (err_clr),
    .glitch_cnt  (glitch_cnt)
  );

  always #6 clk = ~clk;

  // Record every handshake; inputs only change just after rising edges.
  always @(negedge clk) begin
    if (!rst && cmd_valid && cmd_ready) begin
      hs_q.push_back({cmd_wr, cmd_a, cmd_d});
      hs_cnt++;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int cnt);
    repeat (cnt) @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic rd, input logic wr);
    cs_n = 1'b0; iord_n = ~rd; iowr_n = ~wr;
  endtask

  task automatic release_bus();
    cs_n = 1'b1; iord_n = 1'b1; iowr_n = 1'b1;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 50 && busy; i++) cyc(1);
    check(tag, 32'(busy), 32'd0);
  endtask

  task automatic wait_valid();
    n = 0;
    while (!cmd_valid && n < 20) begin
      cyc(1);
      n++;
    end
  endtask

  function automatic logic [31:0] pop_hs();
    if (hs_q.size() == 0) return 32'hFFFF_FFFF;
    return {21'd0, hs_q.pop_front()};
  endfunction

  initial begin
    // Reset values
    cyc(3);
    check("rst_valid", 32'(cmd_valid), 32'd0);
    check("rst_wr", 32'(cmd_wr), 32'd0);
    check("rst_a", 32'(cmd_a), 32'd0);
    check("rst_d", 32'(cmd_d), 32'd0);
    check("rst_late", 32'(err_late), 32'd0);
    check("rst_ill", 32'(err_illegal), 32'd0);
    check("rst_glitch", 32'(glitch_cnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    wait_idle("rst_idle");

    // Write reg 2 = 55, always ready
    cmd_ready = 1'b1; a = REG_A_LO; d = 8'h55; hs_base = hs_cnt;
    strobe(1'b0, 1'b1);
    wait_valid();
    check("wr_latency", 32'(n), 32'd5);
    check("wr_fields", {21'd0, cmd_wr, cmd_a, cmd_d}, {21'd0, 1'b1, 2'd2, 8'h55});
    cyc(162);
    release_bus();
    cyc(10);
    check("wr_count", 32'(hs_cnt - hs_base), 32'd1);
    check("wr_hs", pop_hs(), {21'd0, 1'b1, 2'd2, 8'h55});
    check("wr_late", 32'(err_late), 32'd0);
    wait_idle("wr_idle");

    // Read reg 0 with a stalled core; strobe released at cycle 20
    cmd_ready = 1'b0; a = REG_DATA; d = 8'h77; hs_base = hs_cnt;
    strobe(1'b1, 1'b0);
    wait_valid();
    check("rd_latency", 32'(n), 32'd5);
    snap = {cmd_wr, cmd_a, cmd_d};
    stable = 1'b1;
    for (int i = n; i < 40; i++) begin
      if (i == 20) release_bus();
      cyc(1);
      if (!cmd_valid || {cmd_wr, cmd_a, cmd_d} !== snap) stable = 1'b0;
    end
    check("rd_stable", 32'(stable), 32'd1);
    check("rd_fields", {21'd0, snap}, {21'd0, 1'b0, 2'd0, 8'h00});
    check("rd_late", 32'(err_late), 32'd1);
    cmd_ready = 1'b1;
    cyc(1);
    check("rd_valid_fall", 32'(cmd_valid), 32'd0);
    check("rd_recover", 32'(busy), 32'd1);
    check("rd_count", 32'(hs_cnt - hs_base), 32'd1);
    check("rd_hs", pop_hs(), {21'd0, 1'b0, 2'd0, 8'h00});
    wait_idle("rd_idle");
    err_clr = 1'b1; cyc(1); err_clr = 1'b0;
    check("rd_late_clr", 32'(err_late), 32'd0);

    // Two-cycle write glitches
    hs_base = hs_cnt; a = REG_IRQ;
    strobe(1'b0, 1'b1); cyc(2); release_bus(); cyc(6);
    check("glitch_one", 32'(glitch_cnt), 32'd1);
    repeat (299) begin
      strobe(1'b0, 1'b1); cyc(2); release_bus(); cyc(4);
    end
    cyc(4);
    check("glitch_sat", 32'(glitch_cnt), 32'hFF);
    check("glitch_nocmd", 32'(hs_cnt - hs_base), 32'd0);
    wait_idle("glitch_idle");

    // Both strobes low together
    strobe(1'b1, 1'b1); cyc(10); release_bus(); cyc(8);
    check("ill_flag", 32'(err_illegal), 32'd1);
    check("ill_nocmd", 32'(hs_cnt - hs_base), 32'd0);
    check("ill_notbusy", 32'(busy), 32'd0);
    err_clr = 1'b1; cyc(1); err_clr = 1'b0;
    check("ill_clr", 32'(err_illegal), 32'd0);

    // Reset during a pending write discards it
    cmd_ready = 1'b0; a = REG_IRQ; d = 8'h11; hs_base = hs_cnt;
    strobe(1'b0, 1'b1);
    cyc(8);
    check("rst_pend", 32'(cmd_valid), 32'd1);
    rst = 1'b1; #1;
    check("rst_abort", 32'(cmd_valid), 32'd0);
    cyc(2);
    rst = 1'b0; cmd_ready = 1'b1;
    cyc(30);
    release_bus();
    cyc(10);
    check("rst_nocmd", 32'(hs_cnt - hs_base), 32'd0);
    wait_idle("rst2_idle");
    a = REG_A_HI; d = 8'hAA;
    strobe(1'b0, 1'b1); cyc(167); release_bus(); cyc(10);
    check("post_rst_count", 32'(hs_cnt - hs_base), 32'd1);
    check("post_rst_hs", pop_hs(), {21'd0, 1'b1, 2'd3, 8'hAA});

    // Four data writes with short release gaps
    wvals[0] = 8'hAA; wvals[1] = 8'hBB; wvals[2] = 8'hCC; wvals[3] = 8'hDD;
    hs_base = hs_cnt; a = REG_DATA;
    for (int i = 0; i < 4; i++) begin
      d = wvals[i];
      strobe(1'b0, 1'b1); cyc(167); release_bus(); cyc(8);
    end
    cyc(10);
    check("seq_count", 32'(hs_cnt - hs_base), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("seq_hs%0d", i), pop_hs(), {21'd0, 1'b1, 2'd0, wvals[i]});
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
